mem_port_arbiter: RTL

- Shares the single unified instruction/data memory port of the multicycle MIPS core between two requesters: the CPU, which issues fetch and load/store accesses, and an external loader/debug port.
- Sits between the control_unit/datapath memory signals and the memory array.
- Sequences each access through a request/grant/acknowledge FSM that allows for memory latency.
- Produces a stall for the CPU state machine while a CPU access is pending.

---
 rtl/mem_port_arbiter.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the unified memory port of the multicycle MIPS core between
// the CPU and an external loader/debug requester using a request/grant/ack FSM.
// IDLE -> ACCESS (mem_en in first cycle, MEM_LAT+1 cycles for reads) -> ACK -> IDLE.
// Optional feature macro ARB_ROUND_ROBIN_EN: alternate priority on contention instead of
// fixed CPU priority with the starvation override.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              cclk,
  input  logic              rstb,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [3:0] MemLat = 4'(MEM_LAT);

  typedef enum logic [1:0] {StIdle, StAccess, StAck} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;  // 1: ext holds the grant
  logic [3:0]          lat_cnt_q, lat_cnt_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   ext_rdata_q, ext_rdata_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                ext_ack_q, ext_ack_d;

  logic                contended;
  logic                any_req;
  logic                ext_prio;
  logic                ext_pick;

  // Arbitration: a lone requester always wins; contention is settled by ext_prio.
  always_comb begin
    contended = cpu_req & ext_req;
    any_req   = cpu_req | ext_req;
    if (contended) begin
      ext_pick = ext_prio;
    end else begin
      ext_pick = ext_req;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_ext_prio_q, rr_ext_prio_d;

  assign ext_prio = rr_ext_prio_q;

  // Priority flips to whoever lost the last contended arbitration.
  always_comb begin
    rr_ext_prio_d = rr_ext_prio_q;
    if (state_q == StIdle && contended) begin
      rr_ext_prio_d = ~ext_pick;
    end
  end

  // Round-robin priority register; CPU wins the first contention after reset.
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      rr_ext_prio_q <= 1'b0;
    end else begin
      rr_ext_prio_q <= rr_ext_prio_d;
    end
  end
`else
  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  logic [3:0] starve_cnt_q, starve_cnt_d;

  assign ext_prio = (starve_cnt_q == StarveMax);

  // Count contended CPU wins, saturating; any ext grant clears the count.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (state_q == StIdle && any_req) begin
      if (ext_pick) begin
        starve_cnt_d = 4'd0;
      end else if (contended && starve_cnt_q < StarveMax) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`endif

  // FSM next state and registered outputs.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lat_cnt_d   = lat_cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    ext_rdata_d = ext_rdata_q;
    cpu_ack_d   = 1'b0;
    ext_ack_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          owner_d  = ext_pick;
          mem_en_d = 1'b1;
          if (ext_pick) begin
            mem_we_d    = ext_we;
            mem_addr_d  = ext_addr;
            mem_wdata_d = ext_wdata;
          end else begin
            mem_we_d    = cpu_we;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
          end
          // Writes finish after one ACCESS cycle; reads wait out the memory latency.
          lat_cnt_d = mem_we_d ? 4'd0 : MemLat;
          state_d   = StAccess;
        end
      end
      StAccess: begin
        if (lat_cnt_q == 4'd0) begin
          if (!mem_we_q) begin
            if (owner_q) begin
              ext_rdata_d = mem_rdata;
            end else begin
              cpu_rdata_d = mem_rdata;
            end
          end
          cpu_ack_d = ~owner_q;
          ext_ack_d = owner_q;
          state_d   = StAck;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM state and output registers; reset abandons any in-flight access.
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      lat_cnt_q   <= 4'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      ext_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_cnt_q   <= lat_cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ext_rdata_q <= ext_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      ext_ack_q   <= ext_ack_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ext_rdata = ext_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign ext_ack   = ext_ack_q;
  assign cpu_stall = cpu_req & ~cpu_ack_q;
  assign busy      = (state_q != StIdle);

endmodule
